// File: rtl/lcd_timing.sv
// ============================================================================
// lcd_timing
// ----------------------------------------------------------------------------
// Game Boy LCD timing generator. Runs the per-dot line/frame counters, holds
// the CPU-visible LCD registers LCDC (FF40), STAT (FF41), LY (FF44) and
// LYC (FF45), and raises VBlank / LCD-STAT interrupt request pulses.
//
// Ports:
//   clock       CPU clock, one dot per cycle
//   reset       asynchronous, active-high
//   addr        CPU bus address
//   data_in     CPU write data
//   we          CPU write strobe (sampled on rising clock edge)
//   re          CPU read strobe
//   data_out    register read data, 8'h00 when not hit (combinational)
//   hit         re asserted and addr is one of the four LCD registers
//   ly          current line
//   mode        current STAT mode
//   irq_vblank  one-cycle VBlank request
//   irq_stat    one-cycle STAT request
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timing #(
   parameter int DOTS_PER_LINE   = 456,
   parameter int LINES_PER_FRAME = 154,
   parameter int VBLANK_LINE     = 144,
   parameter int MODE2_DOTS      = 80,
   parameter int MODE3_DOTS      = 172
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   input  logic        we,
   input  logic        re,
   output logic [7:0]  data_out,
   output logic        hit,
   output logic [7:0]  ly,
   output logic [1:0]  mode,
   output logic        irq_vblank,
   output logic        irq_stat
);

   localparam int DOT_W = $clog2(DOTS_PER_LINE);

   localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(DOTS_PER_LINE - 1);
   localparam logic [DOT_W-1:0] DOT_MODE3 = DOT_W'(MODE2_DOTS);
   localparam logic [DOT_W-1:0] DOT_MODE0 = DOT_W'(MODE2_DOTS + MODE3_DOTS);
   localparam logic [7:0]       LY_LAST   = 8'(LINES_PER_FRAME - 1);
   localparam logic [7:0]       LY_VBLANK = 8'(VBLANK_LINE);

   localparam logic [1:0] MODE_HBLANK = 2'd0;
   localparam logic [1:0] MODE_VBLANK = 2'd1;
   localparam logic [1:0] MODE_OAM    = 2'd2;
   localparam logic [1:0] MODE_XFER   = 2'd3;

   logic [DOT_W-1:0] dot;
   logic [7:0]       lcdc;
   logic [3:0]       stat_en;      // STAT[6:3]
   logic [7:0]       lyc;
   logic             coincidence;
   logic             stat_line;

   logic             sel_lcdc, sel_stat, sel_ly, sel_lyc;
   logic             wr_lcdc, wr_stat, wr_ly, wr_lyc;
   logic             lcd_on_next;
   logic [DOT_W-1:0] dot_inc;
   logic [7:0]       ly_inc;
   logic             stat_line_next;

   // Mode for a given counter position; used on the next-state values so
   // that mode is registered alongside dot/ly.
   function automatic logic [1:0] mode_of(input logic [DOT_W-1:0] d,
                                          input logic [7:0]       l);
      if (l >= LY_VBLANK)      return MODE_VBLANK;
      else if (d < DOT_MODE3)  return MODE_OAM;
      else if (d < DOT_MODE0)  return MODE_XFER;
      else                     return MODE_HBLANK;
   endfunction

   always_comb begin
      sel_lcdc = (addr == 16'hFF40);
      sel_stat = (addr == 16'hFF41);
      sel_ly   = (addr == 16'hFF44);
      sel_lyc  = (addr == 16'hFF45);

      wr_lcdc = we & sel_lcdc;
      wr_stat = we & sel_stat;
      wr_ly   = we & sel_ly;
      wr_lyc  = we & sel_lyc;

      // A write disabling the LCD takes effect on the same edge, so it
      // overrides any wrap or IRQ that edge would otherwise produce.
      lcd_on_next = wr_lcdc ? data_in[7] : lcdc[7];

      if (dot == DOT_LAST) begin
         dot_inc = '0;
         ly_inc  = (ly == LY_LAST) ? 8'd0 : ly + 8'd1;
      end else begin
         dot_inc = dot + 1'b1;
         ly_inc  = ly;
      end

      stat_line_next = (stat_en[3] & coincidence)
                     | (stat_en[2] & (mode == MODE_OAM))
                     | (stat_en[1] & (mode == MODE_VBLANK))
                     | (stat_en[0] & (mode == MODE_HBLANK));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dot         <= '0;
         ly          <= 8'd0;
         lcdc        <= 8'h80;
         stat_en     <= 4'd0;
         lyc         <= 8'd0;
         coincidence <= 1'b0;
         stat_line   <= 1'b0;
         mode        <= MODE_OAM;
         irq_vblank  <= 1'b0;
         irq_stat    <= 1'b0;
      end else begin
         if (wr_lcdc) lcdc    <= data_in;
         if (wr_stat) stat_en <= data_in[6:3];
         if (wr_lyc)  lyc     <= data_in;

         if (!lcd_on_next) begin
            dot        <= '0;
            ly         <= 8'd0;
            mode       <= MODE_HBLANK;
            irq_vblank <= 1'b0;
            irq_stat   <= 1'b0;
            stat_line  <= 1'b0;
         end else begin
            // Re-enable and an LY write both restart at line 0, dot 0.
            // The clear path never raises VBlank.
            if (!lcdc[7] || wr_ly) begin
               dot        <= '0;
               ly         <= 8'd0;
               mode       <= MODE_OAM;
               irq_vblank <= 1'b0;
            end else begin
               dot        <= dot_inc;
               ly         <= ly_inc;
               mode       <= mode_of(dot_inc, ly_inc);
               irq_vblank <= (dot_inc == '0) && (ly_inc == LY_VBLANK);
            end

            // Interrupt edge detection starts one cycle after re-enable so
            // the mode left over from the disabled period cannot fire.
            if (lcdc[7]) begin
               coincidence <= (ly == lyc);
               stat_line   <= stat_line_next;
               irq_stat    <= stat_line_next & ~stat_line;
            end else begin
               stat_line   <= 1'b0;
               irq_stat    <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      hit      = re & (sel_lcdc | sel_stat | sel_ly | sel_lyc);
      data_out = 8'h00;
      if (re) begin
         if (sel_lcdc)     data_out = lcdc;
         else if (sel_stat) data_out = {1'b1, stat_en, coincidence, mode};
         else if (sel_ly)   data_out = ly;
         else if (sel_lyc)  data_out = lyc;
      end
   end

endmodule

`default_nettype wire
